pc_stage: RTL and testbench

PC_STAGE -- requirements
Module: pc_stage

---
 rtl/pc_stage.sv | 123 ++++++++++++
 tb/tb_pc_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_stage.sv
// Fetch-stage program counter: boot sequencing, stall/branch/flush redirect with a single pending slot.
// Optional fetch-alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  input  logic [31:0] exc_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic        rom_en,
  output logic        redirect_pending,
  output logic        pc_misaligned
);

  localparam int unsigned PcW     = 32;
  localparam logic [PcW-1:0] BootPc = PcW'(32'hbfc0_0000);
  localparam logic [PcW-1:0] PcStep = PcW'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [PcW-1:0] r_pc;
  logic [PcW-1:0] w_pc_nxt;
  logic           r_pend;
  logic           w_pend_nxt;
  logic [PcW-1:0] r_pend_addr;
  logic [PcW-1:0] w_pend_addr_nxt;
  logic           r_rom_en;
  logic           w_rom_en_nxt;

  // Next-state / next-pc: flush > stall > pending target > branch > sequential.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, HOLD: begin
        if (flush) begin
          w_pc_nxt        = exc_pc;
          w_pend_nxt      = 1'b0;
          w_pend_addr_nxt = '0;
          w_state_nxt     = RUN;
        end else if (stall_pc) begin
          // Only the first branch seen under stall is captured.
          if (r_state == RUN && branch_flag) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = branch_addr;
            w_state_nxt     = HOLD;
          end
        end else if (r_pend) begin
          w_pc_nxt        = r_pend_addr;
          w_pend_nxt      = 1'b0;
          w_pend_addr_nxt = '0;
          w_state_nxt     = RUN;
        end else if (branch_flag) begin
          w_pc_nxt    = branch_addr;
          w_state_nxt = RUN;
        end else begin
          w_pc_nxt    = r_pc + PcStep;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_misaligned;
  logic w_misaligned_nxt;

  always_comb begin
    w_misaligned_nxt = (w_pc_nxt[1:0] != 2'b00);
    w_rom_en_nxt     = (w_state_nxt != BOOT) && !w_misaligned_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_misaligned <= 1'b0;
    else     r_misaligned <= w_misaligned_nxt;
  end

  assign pc_misaligned = r_misaligned;
`else
  always_comb begin
    w_rom_en_nxt = (w_state_nxt != BOOT);
  end

  assign pc_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= BootPc;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_rom_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_rom_en    <= w_rom_en_nxt;
    end
  end

  assign pc               = r_pc;
  assign rom_en           = r_rom_en;
  assign redirect_pending = r_pend;

endmodule

// File: tb/tb_pc_stage.sv
// Directed self-checking bench for pc_stage; honours PC_ALIGN_CHECK_EN for the alignment case.
module tb_pc_stage;

  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        flush;
  logic [31:0] exc_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic        rom_en;
  logic        redirect_pending;
  logic        pc_misaligned;

  int n_total;
  int n_bad;

  pc_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_pc         (stall_pc),
    .flush            (flush),
    .exc_pc           (exc_pc),
    .branch_flag      (branch_flag),
    .branch_addr      (branch_addr),
    .pc               (pc),
    .rom_en           (rom_en),
    .redirect_pending (redirect_pending),
    .pc_misaligned    (pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_rom,
                         input logic e_pend);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".rom_en"}, 32'(rom_en), 32'(e_rom));
    chk({tag, ".pend"}, 32'(redirect_pending), 32'(e_pend));
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    stall_pc    = 1'b0;
    flush       = 1'b0;
    exc_pc      = '0;
    branch_flag = 1'b0;
    branch_addr = '0;

    // Reset and boot sequence
    tick();
    tick();
    chk_all("reset", 32'hbfc0_0000, 1'b0, 1'b0);
    chk("reset.mis", 32'(pc_misaligned), 32'd0);
    rst = 1'b0;
    chk_all("boot_c1", 32'hbfc0_0000, 1'b0, 1'b0);
    tick();
    chk_all("boot_c2", 32'hbfc0_0000, 1'b1, 1'b0);
    tick();
    chk_all("seq1", 32'hbfc0_0004, 1'b1, 1'b0);
    tick();
    chk_all("seq2", 32'hbfc0_0008, 1'b1, 1'b0);

    // Unstalled branch
    branch_flag = 1'b1; branch_addr = 32'hbfc0_0100;
    tick();
    chk_all("br", 32'hbfc0_0100, 1'b1, 1'b0);

    // Branch under stall: first capture wins, applied over a simultaneous branch
    stall_pc = 1'b1; branch_addr = 32'h8000_0040;
    tick();
    chk_all("st1", 32'hbfc0_0100, 1'b1, 1'b1);
    branch_addr = 32'h8000_0080;
    tick();
    chk_all("st2", 32'hbfc0_0100, 1'b1, 1'b1);
    branch_flag = 1'b0;
    tick();
    chk_all("st3", 32'hbfc0_0100, 1'b1, 1'b1);
    stall_pc = 1'b0; branch_flag = 1'b1; branch_addr = 32'h1234_5678;
    tick();
    chk_all("st_rel", 32'h8000_0040, 1'b1, 1'b0);
    branch_flag = 1'b0;
    tick();
    chk_all("st_seq", 32'h8000_0044, 1'b1, 1'b0);

    // Flush in HOLD discards pending target
    stall_pc = 1'b1; branch_flag = 1'b1; branch_addr = 32'h9000_0000;
    tick();
    chk_all("hold", 32'h8000_0044, 1'b1, 1'b1);
    branch_flag = 1'b0; flush = 1'b1; exc_pc = 32'hbfc0_0380;
    tick();
    chk_all("flush", 32'hbfc0_0380, 1'b1, 1'b0);
    flush = 1'b0; stall_pc = 1'b0;
    tick();
    chk_all("flush_seq", 32'hbfc0_0384, 1'b1, 1'b0);

    // Plain stall without branch
    stall_pc = 1'b1;
    tick();
    chk_all("stall_only", 32'hbfc0_0384, 1'b1, 1'b0);
    stall_pc = 1'b0;

    // Modulo-2^32 wrap
    branch_flag = 1'b1; branch_addr = 32'hffff_fffc;
    tick();
    chk_all("wrap0", 32'hffff_fffc, 1'b1, 1'b0);
    branch_flag = 1'b0;
    tick();
    chk_all("wrap1", 32'h0000_0000, 1'b1, 1'b0);
    tick();
    chk_all("wrap2", 32'h0000_0004, 1'b1, 1'b0);

    // Reset mid-HOLD dominates flush
    stall_pc = 1'b1; branch_flag = 1'b1; branch_addr = 32'h0000_0100;
    tick();
    chk_all("pre_rst", 32'h0000_0004, 1'b1, 1'b1);
    rst = 1'b1; flush = 1'b1; exc_pc = 32'h0000_0200;
    tick();
    chk_all("rst_hold", 32'hbfc0_0000, 1'b0, 1'b0);
    rst = 1'b0; flush = 1'b0; stall_pc = 1'b0; branch_flag = 1'b0;
    tick();
    chk_all("reboot", 32'hbfc0_0000, 1'b1, 1'b0);
    tick();
    chk_all("reboot_seq", 32'hbfc0_0004, 1'b1, 1'b0);

    // Misaligned target
    branch_flag = 1'b1; branch_addr = 32'hbfc0_0102;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk_all("mis", 32'hbfc0_0102, 1'b0, 1'b0);
    chk("mis.flag", 32'(pc_misaligned), 32'd1);
`else
    chk_all("mis", 32'hbfc0_0102, 1'b1, 1'b0);
    chk("mis.flag", 32'(pc_misaligned), 32'd0);
`endif
    branch_addr = 32'hbfc0_0200;
    tick();
    chk_all("realign", 32'hbfc0_0200, 1'b1, 1'b0);
    chk("realign.flag", 32'(pc_misaligned), 32'd0);
    branch_flag = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
